// File: rtl/resolution_text_reader.sv
// resolution_text_reader
//   Fetches the resolution-label text row that falls on the current video
//   line from the resolution ROM and serialises it, MSB first, into a
//   per-pixel pixel_on signal inside a fixed on-screen box.
//
// Ports:
//   clock     pixel clock
//   reset_n   asynchronous active-low reset
//   new_line  one-cycle pulse at start of line; y valid while high
//   x, y      12-bit video timing counters
//   rom_addr  registered 4-bit row address to the ROM
//   rom_q     ROM row data, valid 1 clock after rom_addr changes
//   pixel_on  registered text pixel
//   in_box    registered "pixel inside text box" flag

`ifndef RESLINE_SIZE
`define RESLINE_SIZE 48
`endif

module resolution_text_reader #(
    parameter int unsigned WIDTH      = `RESLINE_SIZE,
    parameter int unsigned X0         = 16,
    parameter int unsigned Y0         = 16,
    parameter int unsigned SCALE_LOG2 = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             new_line,
    input  logic [11:0]      x,
    input  logic [11:0]      y,
    output logic [3:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_q,
    output logic             pixel_on,
    output logic             in_box
);

    localparam int unsigned   BW       = $clog2(WIDTH + 1);
    localparam logic [12:0]   X_START  = 13'(X0);
    localparam logic [12:0]   Y_START  = 13'(Y0);
    localparam logic [12:0]   Y_STOP   = 13'(Y0 + (16 << SCALE_LOG2));
    localparam logic [2:0]    SUB_LAST = 3'((1 << SCALE_LOG2) - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WAIT_X, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] linebuf;
    logic [2:0]       subcnt;
    logic [BW-1:0]    bitcnt;

    // 13-bit comparisons so Y0 + box height can never wrap.
    logic [12:0] x_ext;
    logic [12:0] y_ext;
    logic [12:0] y_off;
    logic        hit;
    logic [3:0]  row;

    always_comb begin
        x_ext = {1'b0, x};
        y_ext = {1'b0, y};
        hit   = (y_ext >= Y_START) && (y_ext < Y_STOP);
        y_off = y_ext - Y_START;
        row   = 4'(y_off >> SCALE_LOG2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            pixel_on <= 1'b0;
            in_box   <= 1'b0;
            linebuf  <= '0;
            subcnt   <= '0;
            bitcnt   <= '0;
        end else begin
            // Outputs are only driven high from SHIFT.
            pixel_on <= 1'b0;
            in_box   <= 1'b0;
            if (new_line) begin
                // A new line always wins, aborting any row in progress.
                if (hit) begin
                    rom_addr <= row;
                    state    <= FETCH;
                end else begin
                    state    <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    // ROM is registering its output during this cycle.
                    FETCH: state <= CAPTURE;
                    CAPTURE: begin
                        linebuf <= rom_q;
                        // Too late to start the row at X0: drop this line.
                        if (x_ext >= X_START) state <= IDLE;
                        else                  state <= WAIT_X;
                    end
                    WAIT_X: begin
                        if (x_ext == X_START) begin
                            subcnt <= '0;
                            bitcnt <= '0;
                            state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        pixel_on <= linebuf[WIDTH-1];
                        in_box   <= 1'b1;
                        if (subcnt == SUB_LAST) begin
                            subcnt  <= '0;
                            linebuf <= linebuf << 1;
                            bitcnt  <= bitcnt + BW'(1);
                            if (bitcnt == BIT_LAST) state <= IDLE;
                        end else begin
                            subcnt <= subcnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_resolution_text_reader.sv
// tb_resolution_text_reader
//   Drives two instances (SCALE_LOG2 = 0 and 1) with the same line timing,
//   each with its own registered ROM model, and compares every output each
//   clock against expectations queued when the stimulus is driven.

module tb_resolution_text_reader;

    localparam int W  = 8;
    localparam int X0 = 100;
    localparam int Y0 = 50;

    logic         clock;
    logic         reset_n;
    logic         new_line;
    logic [11:0]  x;
    logic [11:0]  y;
    logic [3:0]   a0, a1;
    logic [W-1:0] q0, q1;
    logic         p0, b0, p1, b1;
    logic [W-1:0] mem [16];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    resolution_text_reader #(.WIDTH(W), .X0(X0), .Y0(Y0), .SCALE_LOG2(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .new_line(new_line), .x(x), .y(y),
        .rom_addr(a0), .rom_q(q0), .pixel_on(p0), .in_box(b0)
    );

    resolution_text_reader #(.WIDTH(W), .X0(X0), .Y0(Y0), .SCALE_LOG2(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .new_line(new_line), .x(x), .y(y),
        .rom_addr(a1), .rom_q(q1), .pixel_on(p1), .in_box(b1)
    );

    // ROM with registered output, one per instance.
    always_ff @(posedge clock) begin
        q0 <= mem[a0];
        q1 <= mem[a1];
    end

    typedef struct packed {
        logic       p0;
        logic       b0;
        logic [3:0] a0;
        logic       p1;
        logic       b1;
        logic [3:0] a1;
    } obs_t;

    typedef struct {
        int yv;
        int nl_x;
        int addr0;
        int addr1;
        bit ren0;
        bit ren1;
    } vec_t;

    obs_t sb[$];
    vec_t tbl [9];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pa0      = 0;
    int   pa1      = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Expected pixel after the edge that sampled x == i, for a rendered row.
    function automatic logic exp_pix(input int addr, input int s, input int i);
        int j;
        logic [W-1:0] r;
        j = i - (X0 + 1);
        if (j < 0 || j >= (W << s)) return 1'b0;
        r = mem[addr];
        return r[W - 1 - (j >> s)];
    endfunction

    function automatic logic exp_box(input int s, input int i);
        int j;
        j = i - (X0 + 1);
        return (j >= 0) && (j < (W << s));
    endfunction

    // One video line: x runs 0..last_x, new_line at nl_x (y = yv), and an
    // optional second new_line at ab_x (y = ab_y) that aborts the row.
    task automatic run_line(input int yv, input int nl_x, input int ab_x, input int ab_y,
                            input int ad0, input int ad1, input int ab0, input int ab1,
                            input bit r0, input bit r1, input int last_x);
        obs_t e;
        obs_t got;
        for (int i = 0; i <= last_x; i++) begin
            x        = 12'(i);
            y        = 12'((i >= ab_x) ? ab_y : yv);
            new_line = (i == nl_x) || (i == ab_x);
            e.a0 = 4'((i >= ab_x) ? ab0 : (i >= nl_x) ? ad0 : pa0);
            e.a1 = 4'((i >= ab_x) ? ab1 : (i >= nl_x) ? ad1 : pa1);
            e.p0 = (i < ab_x) && r0 && exp_pix(ad0, 0, i);
            e.b0 = (i < ab_x) && r0 && exp_box(0, i);
            e.p1 = (i < ab_x) && r1 && exp_pix(ad1, 1, i);
            e.b1 = (i < ab_x) && r1 && exp_box(1, i);
            sb.push_back(e);
            @(posedge clock);
            #1;
            got = {p0, b0, a0, p1, b1, a1};
            e = sb.pop_front();
            check($sformatf("pix0 y=%0d x=%0d", yv, i), int'(got.p0), int'(e.p0));
            check($sformatf("box0 y=%0d x=%0d", yv, i), int'(got.b0), int'(e.b0));
            check($sformatf("addr0 y=%0d x=%0d", yv, i), int'(got.a0), int'(e.a0));
            check($sformatf("pix1 y=%0d x=%0d", yv, i), int'(got.p1), int'(e.p1));
            check($sformatf("box1 y=%0d x=%0d", yv, i), int'(got.b1), int'(e.b1));
            check($sformatf("addr1 y=%0d x=%0d", yv, i), int'(got.a1), int'(e.a1));
        end
        new_line = 1'b0;
        if (ab_x <= last_x) begin
            pa0 = ab0;
            pa1 = ab1;
        end else if (nl_x <= last_x) begin
            pa0 = ad0;
            pa1 = ad1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 29 + 7);
        mem[0] = 8'b1010_0000;
        mem[1] = 8'b1100_1001;

        //          y   nl_x addr0 addr1 ren0  ren1
        tbl[0] = '{50,  0,   0,    0,    1'b1, 1'b1};  // first row
        tbl[1] = '{53,  10,  3,    1,    1'b1, 1'b1};  // scaled row select
        tbl[2] = '{49,  0,   3,    1,    1'b0, 1'b0};  // just above box
        tbl[3] = '{82,  0,   3,    1,    1'b0, 1'b0};  // Y0+32, below both
        tbl[4] = '{60,  97,  10,   5,    1'b1, 1'b1};  // minimum lead of 3
        tbl[5] = '{66,  0,   10,   8,    1'b0, 1'b1};  // past unscaled box only
        tbl[6] = '{81,  50,  10,   15,   1'b0, 1'b1};  // last scaled line
        tbl[7] = '{65,  98,  15,   7,    1'b0, 1'b0};  // late line (lead 2)
        tbl[8] = '{51,  20,  1,    0,    1'b1, 1'b1};  // normal after late

        reset_n  = 1'b0;
        new_line = 1'b0;
        x        = '0;
        y        = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset pix0", int'(p0), 0);
        check("reset box0", int'(b0), 0);
        check("reset addr0", int'(a0), 0);
        check("reset pix1", int'(p1), 0);
        check("reset box1", int'(b1), 0);
        check("reset addr1", int'(a1), 0);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int k = 0; k < 9; k++)
            run_line(tbl[k].yv, tbl[k].nl_x, 1000, 0, tbl[k].addr0, tbl[k].addr1,
                     0, 0, tbl[k].ren0, tbl[k].ren1, 120);

        // Abort: new_line 5 clocks into SHIFT; the refetch is itself late.
        run_line(50, 0, 105, 52, 0, 0, 2, 1, 1'b1, 1'b1, 120);

        // Asynchronous reset in the middle of a SHIFT row.
        run_line(53, 0, 1000, 0, 3, 1, 0, 0, 1'b1, 1'b1, 103);
        #2 reset_n = 1'b0;
        #1;
        check("async rst pix0", int'(p0), 0);
        check("async rst box0", int'(b0), 0);
        check("async rst addr0", int'(a0), 0);
        check("async rst pix1", int'(p1), 0);
        check("async rst box1", int'(b1), 0);
        check("async rst addr1", int'(a1), 0);
        #1 reset_n = 1'b1;
        pa0 = 0;
        pa1 = 0;
        @(posedge clock);
        #1;
        // No new_line: must stay idle even as x passes X0.
        run_line(53, 1000, 1000, 0, 0, 0, 0, 0, 1'b0, 1'b0, 120);
        run_line(51, 5, 1000, 0, 1, 0, 0, 0, 1'b1, 1'b1, 120);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/resolution_text_reader.md
# resolution_text_reader

Pixel-side reader for the resolution text ROM: on every video line it works out which text row of the resolution label falls on that line and fetches it through the ROM's 4-bit address port. It then serialises the captured `RESLINE_SIZE`-bit row into a per-pixel `pixel_on` signal inside a fixed on-screen box. It sits between the video timing counters and the OSD pixel mixer, and drives the ROM's `addr` input. The ROM selects its contents from `videoMode` internally, so mode changes take effect on the next line without any action from this block.

## Interface
- `WIDTH`, default `RESLINE_SIZE`: bits per ROM row, equal to the text pixels per row before scaling.
- `X0`, default 16: first active x of the box.
- `Y0`, default 16: first active y of the box.
- `SCALE_LOG2`, default 0: pixel replication factor of 1<<SCALE_LOG2, applied both horizontally and vertically; legal range 0..3.
- Constraints: `X0 + (WIDTH<<SCALE_LOG2)` < 4096; `Y0 + (16<<SCALE_LOG2)` < 4096.

Ports (clock and reset first):
- `clock`  in  1  pixel clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `new_line`  in  1  one-cycle pulse at the start of each video line; `y` is valid while it is high.
- `x`  in  12  horizontal counter; increments by 1 per clock across the active region.
- `y`  in  12  vertical counter; stable for the whole line.
- `rom_addr`  out  4  row address to the resolution ROM; registered.
- `rom_q`  in  WIDTH  ROM data; valid 1 clock after `rom_addr` changes, because the ROM registers its output.
- `pixel_on`  out  1  text pixel is set; registered.
- `in_box`  out  1  current pixel lies inside the text box; registered.

## Operation
- State machine with states IDLE, FETCH, CAPTURE, WAIT_X, SHIFT.
- Row selection, evaluated when `new_line` is sampled high:
  - `hit` = (`y` >= `Y0`) && (`y` < `Y0 + (16<<SCALE_LOG2)`).
  - `row` = (`y`-`Y0`)>>SCALE_LOG2, truncated to 4 bits.
- `new_line` takes priority from any state:
  - If `hit`: `rom_addr` <= `row`, go to FETCH.
  - If not `hit`: go to IDLE; `rom_addr` holds its value.
  - In both cases `pixel_on` and `in_box` are 0 on the next cycle.
- FETCH → CAPTURE unconditionally; the ROM is loading its output register during this cycle.
- CAPTURE: `linebuf` <= `rom_q`, go to WAIT_X.
  - If `x` >= `X0` in this cycle, the line is late. Go to IDLE instead; that line produces no output.
- WAIT_X: when `x` == `X0`, go to SHIFT and clear `subcnt` and `bitcnt`.
- SHIFT, on each cycle:
  - `pixel_on` <= `linebuf[WIDTH-1]` and `in_box` <= 1.
  - `subcnt` increments. When it wraps at 1<<SCALE_LOG2, `linebuf` shifts left by 1 and `bitcnt` increments.
  - After `bitcnt` reaches `WIDTH` (that is, `WIDTH<<SCALE_LOG2` SHIFT cycles): go to IDLE, and `pixel_on` and `in_box` return to 0.
- Bits are emitted MSB first: `rom_q[WIDTH-1]` is the leftmost pixel.
- Counter widths:
  - `subcnt` is 3 bits.
  - `bitcnt` is ceil(log2(WIDTH+1)) bits.
  - Box comparisons are 13-bit unsigned, so no wrap-around is possible.
- Outside SHIFT, `pixel_on` and `in_box` are 0.

## Timing
- Reset values: `rom_addr`=0, `pixel_on`=0, `in_box`=0, state IDLE, `linebuf`=0, `subcnt`=0, `bitcnt`=0.
- Reset is asynchronous: outputs clear immediately on `reset_n` falling, even mid-SHIFT.
- Fetch latency, with `new_line` sampled at edge t:
  - `rom_addr` valid after edge t.
  - `rom_q` valid after edge t+1.
  - `linebuf` loaded at edge t+2.
- Minimum lead: the clock that has `new_line` high must come at least 3 clocks before the clock that has `x`==`X0`. Otherwise the late-line rule above applies.
- Output latency: 1 clock. Sampling `x`==`X0` at edge c gives `pixel_on` = bit `WIDTH-1` after edge c+1. Each bit is held for 1<<SCALE_LOG2 clocks.
- A `new_line` during SHIFT aborts the row: `pixel_on` and `in_box` are 0 after the next edge, and a fresh fetch starts.

## Test plan
- Reset test: assert `reset_n`=0 in the middle of a SHIFT row. Required: `pixel_on`, `in_box` and `rom_addr` read 0 before the next clock edge; after release, the block stays in IDLE until the next `new_line`.
- Basic row, with ROM row 0 = 4'b1010 followed by zeros, `X0`=100, `Y0`=50, SCALE_LOG2=0, `y`=50, `new_line` at `x`=0. Required: `rom_addr`=0; `pixel_on` reads 1,0,1,0,0… over the clocks after `x`=100,101,102…; `in_box` stays 1 for exactly `WIDTH` clocks.
- Scaling, with SCALE_LOG2=1 and `y`=53. Required: `rom_addr`=1; each bit is held for 2 clocks; `in_box` stays high for 2×`WIDTH` clocks.
- Box edges: drive `y`=49 and then `y`=`Y0`+32 with SCALE_LOG2=1. Required: `rom_addr` is unchanged, and `pixel_on` and `in_box` stay 0 for the whole line.
- Late line: `new_line` arrives only 2 clocks before `x`==`X0`. Required: `pixel_on` and `in_box` stay 0 for that line, and the next normal line renders correctly.
- Abort: pulse `new_line` 5 clocks into SHIFT. Required: `pixel_on` and `in_box` are 0 on the next clock, and `rom_addr` updates to the new row on the same edge.
